// File: rtl/led_pkg.sv
// Shared constants and the gamma lookup for the LED comet-trail PWM stage.
// The gamma table is only referenced when LED_GAMMA_EN is defined.
package led_pkg;

    localparam int LED_N     = 16;
    localparam int LVL_W     = 4;
    localparam int LVL_MAX   = 15;
    localparam int PWM_SLOTS = 15;

    typedef logic [LVL_W-1:0] lvl_t;

    // Perceptual brightness curve: monotonic, with 0 -> 0 and 15 -> 15.
    function automatic lvl_t gamma_map(input lvl_t lvl);
        lvl_t duty;
        case (lvl)
            4'd0:    duty = 4'd0;
            4'd1:    duty = 4'd0;
            4'd2:    duty = 4'd1;
            4'd3:    duty = 4'd1;
            4'd4:    duty = 4'd1;
            4'd5:    duty = 4'd2;
            4'd6:    duty = 4'd2;
            4'd7:    duty = 4'd3;
            4'd8:    duty = 4'd4;
            4'd9:    duty = 4'd5;
            4'd10:   duty = 4'd6;
            4'd11:   duty = 4'd7;
            4'd12:   duty = 4'd9;
            4'd13:   duty = 4'd11;
            4'd14:   duty = 4'd13;
            default: duty = 4'd15;
        endcase
        return duty;
    endfunction

endpackage

// File: rtl/led_tick_div.sv
// Free-running divider: single-cycle tick every DIV clocks (DIV = 1 ticks every cycle).
module led_tick_div #(
    parameter int DIV = 2
) (
    input  logic clk_24m,
    input  logic rst,
    output logic tick
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_last;

    assign w_last = (r_cnt == CNT_LAST);

    // Count 0..DIV-1 and wrap; the tick is the cycle spent at the last count.
    always_ff @(posedge clk_24m) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign tick = w_last;

endmodule

// File: rtl/led_trail_pwm.sv
// Comet-trail PWM stage for the 16-LED chaser: lit LEDs snap to full level and fade out.
// Define LED_GAMMA_EN to map levels through the gamma table instead of a linear duty.
module led_trail_pwm
    import led_pkg::*;
#(
    parameter int N_LED     = LED_N,
    parameter int DECAY_DIV = 1_200_000,
    parameter int PWM_DIV   = 64
) (
    input  logic             clk_24m,
    input  logic             rst,
    input  logic [N_LED-1:0] pat_in,
    output logic [N_LED-1:0] led_out
);

    localparam lvl_t LVL_FULL = lvl_t'(LVL_MAX);
    localparam lvl_t PWM_LAST = lvl_t'(PWM_SLOTS - 1);

    logic             w_decayTick;
    logic             w_pwmTick;
    lvl_t             r_pwmCnt;
    logic [N_LED-1:0] w_lit;
    logic [N_LED-1:0] r_ledOut;

    led_tick_div #(.DIV(DECAY_DIV)) u_decayDiv (
        .clk_24m (clk_24m),
        .rst     (rst),
        .tick    (w_decayTick)
    );

    led_tick_div #(.DIV(PWM_DIV)) u_pwmDiv (
        .clk_24m (clk_24m),
        .rst     (rst),
        .tick    (w_pwmTick)
    );

    // One slot counter shared by every LED keeps all PWM edges phase-aligned.
    always_ff @(posedge clk_24m) begin
        if (rst) begin
            r_pwmCnt <= '0;
        end else if (w_pwmTick) begin
            r_pwmCnt <= (r_pwmCnt == PWM_LAST) ? '0 : r_pwmCnt + 1'b1;
        end
    end

    for (genvar gi = 0; gi < N_LED; gi++) begin : g_led
        lvl_t r_lvl;
        lvl_t w_duty;

        // A reload from the chaser beats a coincident decay step; decay saturates at 0.
        always_ff @(posedge clk_24m) begin
            if (rst) begin
                r_lvl <= '0;
            end else if (!pat_in[gi]) begin
                r_lvl <= LVL_FULL;
            end else if (w_decayTick && (r_lvl != '0)) begin
                r_lvl <= r_lvl - 1'b1;
            end
        end

`ifdef LED_GAMMA_EN
        assign w_duty = gamma_map(r_lvl);
`else
        assign w_duty = r_lvl;
`endif

        assign w_lit[gi] = (r_pwmCnt < w_duty);
    end

    always_ff @(posedge clk_24m) begin
        if (rst) begin
            r_ledOut <= '1;
        end else begin
            r_ledOut <= ~w_lit;
        end
    end

    assign led_out = r_ledOut;

endmodule

// File: tb/tb_led_trail_pwm.sv
// Directed self-checking bench for led_trail_pwm with DECAY_DIV = 8 and PWM_DIV = 1.
// Expected drive is derived from the edge count since reset and the last reload edge of each LED.
module tb_led_trail_pwm;

    localparam int DECAY = 8;
    localparam int PWMD  = 1;

    logic        clk_24m = 1'b0;
    logic        rst     = 1'b1;
    logic [15:0] pat_in  = 16'hFFFF;
    logic [15:0] led_out;

    int checks = 0;
    int errors = 0;
    int edgeN  = 0;
    int lastLoad [16];
    int litCnt [16];

    led_trail_pwm #(
        .N_LED     (16),
        .DECAY_DIV (DECAY),
        .PWM_DIV   (PWMD)
    ) dut (
        .clk_24m (clk_24m),
        .rst     (rst),
        .pat_in  (pat_in),
        .led_out (led_out)
    );

    always #5 clk_24m = ~clk_24m;

    function automatic int expDuty(input int lvl);
`ifdef LED_GAMMA_EN
        case (lvl)
            0, 1:    return 0;
            2, 3, 4: return 1;
            5, 6:    return 2;
            7:       return 3;
            8:       return 4;
            9:       return 5;
            10:      return 6;
            11:      return 7;
            12:      return 9;
            13:      return 11;
            14:      return 13;
            default: return 15;
        endcase
`else
        return lvl;
`endif
    endfunction

    // Level after edge m for an LED last reloaded at edge load; decay ticks land on edges 8, 16, ...
    function automatic int expLvl(input int load, input int m);
        int steps;
        if (load < 0) return 0;
        steps = (m / DECAY) - (load / DECAY);
        return (steps >= 15) ? 0 : 15 - steps;
    endfunction

    task automatic checkOutput(input logic [15:0] expVec, input string tag);
        checks++;
        assert (led_out === expVec)
        else begin
            errors++;
            $error("[TB] FAIL %s: led_out=%h expected=%h (edge %0d)", tag, led_out, expVec, edgeN);
        end
    endtask

    task automatic checkValue(input int observed, input int expected, input string tag);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] pat, input string tag);
        logic [15:0] expVec;
        int m;
        m = edgeN;
        pat_in = pat;
        for (int i = 0; i < 16; i++) begin
            expVec[i] = ((m % 15) < expDuty(expLvl(lastLoad[i], m))) ? 1'b0 : 1'b1;
        end
        @(posedge clk_24m);
        edgeN++;
        for (int i = 0; i < 16; i++) begin
            if (!pat[i]) lastLoad[i] = edgeN;
        end
        #1;
        checkOutput(expVec, tag);
    endtask

    task automatic applyReset(input int cycles, input logic [15:0] pat);
        rst = 1'b1;
        pat_in = pat;
        for (int c = 0; c < cycles; c++) begin
            @(posedge clk_24m);
            #1;
            checkOutput(16'hFFFF, "in_reset");
        end
        rst = 1'b0;
        edgeN = 0;
        for (int i = 0; i < 16; i++) lastLoad[i] = -1;
    endtask

    initial begin
        int sinceLoad;

        // Reset with every LED requested: dark through reset and one cycle after release.
        applyReset(3, 16'h0000);
        applyStimulus(16'h0000, "rst_release_1");
        checkOutput(16'hFFFF, "rst_release_1_hand");
        applyStimulus(16'h0000, "rst_release_2");
        checkOutput(16'h0000, "rst_release_2_hand");
        applyStimulus(16'h0000, "rst_release_3");

        // Steady LED 0 lit for over three PWM periods.
        applyReset(2, 16'hFFFF);
        applyStimulus(16'hFFFE, "steady_first");
        for (int c = 0; c < 50; c++) begin
            applyStimulus(16'hFFFE, "steady");
            checkOutput(16'hFFFE, "steady_hand");
        end

        // Single-cycle pulse on LED 3, then a full fade and no underflow afterwards.
        applyReset(2, 16'hFFFF);
        applyStimulus(16'hFFF7, "fade_load");
        for (int c = 0; c < 140; c++) applyStimulus(16'hFFFF, "fade");
        checkOutput(16'hFFFF, "fade_floor_hand");

        // Reload LED 5 in exactly the decay-tick cycle: level must be 15, never 14.
        while (((edgeN + 1) % DECAY) != 0) applyStimulus(16'hFFFF, "pre_simul");
        applyStimulus(16'hFFDF, "simul_load");
        for (int c = 0; c < DECAY; c++) begin
            applyStimulus(16'hFFFF, "simul_hold");
            checkValue(int'(led_out[5]), 0, "simul_full_level");
        end
        for (int c = 0; c < 20; c++) applyStimulus(16'hFFFF, "simul_decay");

        // Reset in the middle of a fade discards it.
        applyStimulus(16'hFFFE, "midrst_load");
        for (int c = 0; c < 5; c++) applyStimulus(16'hFFFF, "midrst_fade");
        applyReset(1, 16'hFFFF);
        for (int c = 0; c < 10; c++) begin
            applyStimulus(16'hFFFF, "midrst_after");
            checkOutput(16'hFFFF, "midrst_after_hand");
        end

        // Rotating chaser: head at full duty, trail strictly dimmer.
        applyReset(2, 16'hFFFF);
        for (int i = 0; i < 16; i++) litCnt[i] = 0;
        for (int step = 0; step < 6; step++) begin
            for (int c = 0; c < 32; c++) begin
                applyStimulus(~(16'h0001 << step), "chaser");
                if (step == 5 && c >= 17) begin
                    for (int i = 0; i < 16; i++) litCnt[i] += (led_out[i] == 1'b0) ? 1 : 0;
                end
            end
        end
        checkValue(litCnt[5], 15, "chaser_head_lit");
        sinceLoad = (litCnt[5] > litCnt[4]) ? 1 : 0;
        checkValue(sinceLoad, 1, "chaser_trail_4");
        sinceLoad = (litCnt[4] > litCnt[3]) ? 1 : 0;
        checkValue(sinceLoad, 1, "chaser_trail_3");
        sinceLoad = (litCnt[3] > litCnt[2]) ? 1 : 0;
        checkValue(sinceLoad, 1, "chaser_trail_2");
        checkValue(litCnt[15], 0, "chaser_unused_dark");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
